// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler
//   Arbitrates the single uart_tx channel between game-over ('R'), hit ('H')
//   and mole-position ('0'..'4') messages. Requests are held in per-source
//   pending storage and granted one byte at a time by a fixed-priority FSM
//   that follows the transmitter's busy handshake.
//
//   Optional feature macro: UART_SCHED_HIT_QUEUE_EN
//     defined   : hits are counted up to HIT_DEPTH, excess hits pulse hit_overflow
//     undefined : hits collapse to one pending flag, hit_overflow tied to 0
//
// Ports
//   clock, reset      : system clock, synchronous active-high reset
//   flush             : level, clears all pending requests
//   gameover_req      : pulse, request 'R'
//   hit_req           : pulse, request one 'H'
//   mole_valid        : pulse, mole_index (0..4) valid
//   mole_index[2:0]   : mole position
//   tx_busy           : busy flag from uart_tx
//   tx_start          : one-cycle start pulse to uart_tx
//   tx_data[7:0]      : byte for uart_tx, held until the FSM returns to IDLE
//   hit_overflow      : one-cycle pulse, hit dropped because the queue is full
//   timeout_err       : one-cycle pulse, tx_busy never rose after tx_start
//   pending[2:0]      : {gameover_pend, hit pending, mole_pend}
module uart_msg_scheduler #(
  parameter int HIT_DEPTH = 7,
  parameter int BUSY_WAIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       gameover_req,
  input  logic       hit_req,
  input  logic       mole_valid,
  input  logic [2:0] mole_index,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       hit_overflow,
  output logic       timeout_err,
  output logic [2:0] pending
);

`ifdef UART_SCHED_HIT_QUEUE_EN
  localparam int HIT_CAP = HIT_DEPTH;
`else
  // HIT_DEPTH has no effect here: at most one hit is ever pending.
  localparam int HIT_CAP = (HIT_DEPTH < 1) ? 1 : 1;
`endif
  localparam int HW = $clog2(HIT_CAP + 1);
  localparam int WW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  state_t          state, state_nxt;
  logic            gameover_pend;
  logic [HW-1:0]   hit_cnt;
  logic            mole_pend;
  logic [2:0]      mole_reg;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            grant_go, grant_hit, grant_mole;
  logic            start_nxt, timeout_nxt, ovf_nxt;
  logic [7:0]      data_nxt;
  logic            hit_full, mole_ok;

  assign hit_full = (hit_cnt == HW'(HIT_CAP));
  assign mole_ok  = mole_valid && (mole_index <= 3'd4);
  assign pending  = {gameover_pend, hit_cnt != '0, mole_pend};

`ifdef UART_SCHED_HIT_QUEUE_EN
  // A same-cycle grant frees a slot, so a request then is not a drop.
  assign ovf_nxt = hit_req && hit_full && !grant_hit && !flush;
`else
  assign ovf_nxt = 1'b0;
`endif

  // Pending storage
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      gameover_pend <= 1'b0;
      hit_cnt       <= '0;
      mole_pend     <= 1'b0;
      mole_reg      <= '0;
    end else begin
      if (gameover_req)    gameover_pend <= 1'b1;
      else if (grant_go)   gameover_pend <= 1'b0;

      if (hit_req && grant_hit)     hit_cnt <= hit_cnt;
      else if (hit_req && !hit_full) hit_cnt <= hit_cnt + HW'(1);
      else if (grant_hit)           hit_cnt <= hit_cnt - HW'(1);

      // New index wins over a same-cycle grant; the grant already latched the old one.
      if (mole_ok) begin
        mole_reg  <= mole_index;
        mole_pend <= 1'b1;
      end else if (grant_mole) begin
        mole_pend <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and registered-output next values
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    grant_go    = 1'b0;
    grant_hit   = 1'b0;
    grant_mole  = 1'b0;
    start_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    data_nxt    = tx_data;
    case (state)
      IDLE: begin
        wait_nxt = '0;
        // No launch while flushing: the pending bits are being discarded.
        if (!tx_busy && !flush) begin
          if (gameover_pend) begin
            grant_go = 1'b1;
            data_nxt = 8'h52;
          end else if (hit_cnt != '0) begin
            grant_hit = 1'b1;
            data_nxt  = 8'h48;
          end else if (mole_pend) begin
            grant_mole = 1'b1;
            data_nxt   = 8'h30 + {5'd0, mole_reg};
          end
        end
        if (grant_go || grant_hit || grant_mole) begin
          start_nxt = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (tx_busy) begin
          state_nxt = SEND;
        end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      SEND: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_start     <= 1'b0;
      tx_data      <= '0;
      timeout_err  <= 1'b0;
      hit_overflow <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      tx_start     <= start_nxt;
      tx_data      <= data_nxt;
      timeout_err  <= timeout_nxt;
      hit_overflow <= ovf_nxt;
      wait_cnt     <= wait_nxt;
    end
  end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler. A simple UART model raises busy one
// cycle after tx_start for 20 cycles; busy can also be forced to a level.
module tb_uart_msg_scheduler;
  localparam int BW = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       gameover_req = 1'b0;
  logic       hit_req = 1'b0;
  logic       mole_valid = 1'b0;
  logic [2:0] mole_index = 3'd0;
  logic       busy_force = 1'b0;
  logic       busy_val = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       hit_overflow;
  logic       timeout_err;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;
  int ovf_cnt = 0;
  int dbl_start = 0;
  logic prev_start = 1'b0;
  logic [7:0] bq[$];
  int bc[$];
  int tq[$];

`ifdef UART_SCHED_HIT_QUEUE_EN
  localparam int EXP_OVF = 2;
  localparam int EXP_H   = 7;
`else
  localparam int EXP_OVF = 0;
  localparam int EXP_H   = 1;
`endif

  uart_msg_scheduler #(.HIT_DEPTH(7), .BUSY_WAIT(BW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .gameover_req(gameover_req), .hit_req(hit_req),
    .mole_valid(mole_valid), .mole_index(mole_index),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .hit_overflow(hit_overflow), .timeout_err(timeout_err), .pending(pending)
  );

  always #5 clock = ~clock;

  assign tx_busy = busy_force ? busy_val : (model_cnt != 0);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset)              model_cnt <= 0;
    else if (model_cnt != 0) model_cnt <= model_cnt - 1;
    else if (tx_start)      model_cnt <= 20;
  end

  always @(negedge clock) begin
    if (tx_start) begin
      bq.push_back(tx_data);
      bc.push_back(cyc);
    end
    if (tx_start && prev_start) dbl_start <= dbl_start + 1;
    prev_start <= tx_start;
    if (hit_overflow) ovf_cnt <= ovf_cnt + 1;
    if (timeout_err)  tq.push_back(cyc);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int c0, b0, o0, t0;
    // Reset
    step(3);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_pending", {29'd0, pending}, 0);
    chk("rst_ovf", {31'd0, hit_overflow}, 0);
    chk("rst_timeout", {31'd0, timeout_err}, 0);
    reset = 1'b0;
    step(2);

    // Single hit: 2-cycle latency, 'H'
    b0 = bq.size(); c0 = cyc;
    hit_req = 1'b1; step(); hit_req = 1'b0;
    chk("hit_pending", {29'd0, pending}, 32'b010);
    chk("hit_start_early", {31'd0, tx_start}, 0);
    step();
    chk("hit_start", {31'd0, tx_start}, 1);
    chk("hit_data", {24'd0, tx_data}, 32'h48);
    step();
    chk("hit_start_1cyc", {31'd0, tx_start}, 0);
    step(30);
    chk("hit_nbytes", bq.size() - b0, 1);
    chk("hit_latency", bc[b0] - c0, 2);
    chk("hit_pending_after", {29'd0, pending}, 0);

    // Contention: R, H, '3' in priority order, 23 cycles apart
    b0 = bq.size();
    gameover_req = 1'b1; hit_req = 1'b1; mole_valid = 1'b1; mole_index = 3'd3;
    step();
    gameover_req = 1'b0; hit_req = 1'b0; mole_valid = 1'b0;
    chk("pri_pending", {29'd0, pending}, 32'b111);
    step(90);
    chk("pri_nbytes", bq.size() - b0, 3);
    if (bq.size() - b0 == 3) begin
      chk("pri_b0", {24'd0, bq[b0]}, 32'h52);
      chk("pri_b1", {24'd0, bq[b0+1]}, 32'h48);
      chk("pri_b2", {24'd0, bq[b0+2]}, 32'h33);
      chk("pri_gap1", bc[b0+1] - bc[b0], 23);
      chk("pri_gap2", bc[b0+2] - bc[b0+1], 23);
    end
    chk("pri_pending_after", {29'd0, pending}, 0);

    // Nine hits while busy held high
    b0 = bq.size(); o0 = ovf_cnt;
    busy_force = 1'b1; busy_val = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      hit_req = 1'b1; step(); hit_req = 1'b0; step();
    end
    step(2);
    chk("q_ovf", ovf_cnt - o0, EXP_OVF);
    chk("q_pending", {29'd0, pending}, 32'b010);
    chk("q_none_while_busy", bq.size() - b0, 0);
    busy_force = 1'b0;
    step(200);
    chk("q_nbytes", bq.size() - b0, EXP_H);
    for (int i = b0; i < bq.size(); i++) chk("q_byte", {24'd0, bq[i]}, 32'h48);
    chk("q_pending_after", {29'd0, pending}, 0);

    // Mole: latest value wins, out-of-range ignored
    b0 = bq.size();
    busy_force = 1'b1; busy_val = 1'b1;
    mole_valid = 1'b1; mole_index = 3'd1; step();
    mole_valid = 1'b0; step(2);
    mole_valid = 1'b1; mole_index = 3'd4; step();
    mole_valid = 1'b0; step(2);
    busy_force = 1'b0;
    step(40);
    chk("mole_nbytes", bq.size() - b0, 1);
    if (bq.size() - b0 == 1) chk("mole_byte", {24'd0, bq[b0]}, 32'h34);
    b0 = bq.size();
    mole_valid = 1'b1; mole_index = 3'd6; step();
    mole_valid = 1'b0;
    chk("mole6_pending", {29'd0, pending}, 0);
    step(10);
    chk("mole6_nbytes", bq.size() - b0, 0);

    // Busy never rises: timeout after BUSY_WAIT cycles, then normal launch
    b0 = bq.size(); t0 = tq.size();
    busy_force = 1'b1; busy_val = 1'b0;
    hit_req = 1'b1; step(); hit_req = 1'b0;
    step(25);
    chk("to_nbytes", bq.size() - b0, 1);
    chk("to_count", tq.size() - t0, 1);
    if (tq.size() - t0 == 1 && bq.size() - b0 == 1)
      chk("to_delay", tq[t0] - bc[b0], BW);
    chk("to_pending", {29'd0, pending}, 0);
    step(10);
    busy_force = 1'b0;
    step(2);
    b0 = bq.size(); c0 = cyc;
    gameover_req = 1'b1; step(); gameover_req = 1'b0;
    step(30);
    chk("to_next_nbytes", bq.size() - b0, 1);
    if (bq.size() - b0 == 1) begin
      chk("to_next_byte", {24'd0, bq[b0]}, 32'h52);
      chk("to_next_latency", bc[b0] - c0, 2);
    end

    // Flush during an in-flight 'R'
    b0 = bq.size();
    gameover_req = 1'b1; step(); gameover_req = 1'b0;
    step(5);
    hit_req = 1'b1; step(); hit_req = 1'b0;
    chk("fl_pending_before", {29'd0, pending}, 32'b010);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_pending", {29'd0, pending}, 0);
    step(40);
    chk("fl_nbytes", bq.size() - b0, 1);
    if (bq.size() - b0 == 1) chk("fl_byte", {24'd0, bq[b0]}, 32'h52);
    chk("fl_pending_after", {29'd0, pending}, 0);
    b0 = bq.size();
    mole_valid = 1'b1; mole_index = 3'd2; step(); mole_valid = 1'b0;
    step(30);
    chk("fl_next_nbytes", bq.size() - b0, 1);
    if (bq.size() - b0 == 1) chk("fl_next_byte", {24'd0, bq[b0]}, 32'h32);

    chk("total_timeouts", tq.size(), 1);
    chk("start_one_cycle", dbl_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
